// File: rtl/muldiv_pkg.sv
// Shared types and constants for the Hi/Lo multiply/divide controller.
package muldiv_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } op_e;

  localparam logic [4:0] ChoiceNone = 5'b00000;
  localparam logic [4:0] ChoiceMfhi = 5'b10000;
  localparam logic [4:0] ChoiceMflo = 5'b01000;
  localparam logic [4:0] ChoiceMthi = 5'b00100;
  localparam logic [4:0] ChoiceMtlo = 5'b00010;
  localparam logic [4:0] ChoiceDm   = 5'b00001;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StWb
  } state_e;

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Request/response bundle between the decode stage and the mul/div controller.
interface hilo_muldiv_ctrl_if
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) ();
  logic             op_valid;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [4:0]       cpu_choice;
  logic [4:0]       choice;
  logic [WIDTH-1:0] mul_h;
  logic [WIDTH-1:0] mul_l;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;

  modport master (
    output op_valid, op, rs_val, rt_val, cpu_choice,
    input  choice, mul_h, mul_l, busy, stall, done, div_by_zero
  );

  modport slave (
    input  op_valid, op, rs_val, rt_val, cpu_choice,
    output choice, mul_h, mul_l, busy, stall, done, div_by_zero
  );
endinterface

// File: rtl/hilo_muldiv_datapath.sv
// Iterative unsigned datapath: one shift-add or restoring shift-subtract step per cycle.
module hilo_muldiv_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [WIDTH-1:0] r_acc, r_q, r_b;
  logic [WIDTH:0]   w_sum, w_shl;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Multiply: {carry, acc, q} shifts right; divide: {rem, q} shifts left.
  assign w_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
  assign w_shl  = {r_acc, r_q[WIDTH-1]};
  assign w_ge   = w_shl >= {1'b0, r_b};
  assign w_diff = w_shl[WIDTH-1:0] - r_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_q   <= '0;
      r_b   <= '0;
    end else if (i_load) begin
      r_acc <= '0;
      r_q   <= i_a;
      r_b   <= i_b;
    end else if (i_step) begin
      if (i_is_div) begin
        r_acc <= w_ge ? w_diff : w_shl[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], w_ge};
      end else begin
        r_acc <= w_sum[WIDTH:1];
        r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
      end
    end
  end

  assign o_hi = r_acc;
  assign o_lo = r_q;
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller with Hi/Lo command muxing and pipeline stall.
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  hilo_muldiv_ctrl_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           r_state, w_state_nxt;
  logic [CntW-1:0]  r_cnt;
  logic             r_is_div, r_sign_a, r_sign_b, r_dbz;
  logic [WIDTH-1:0] r_mul_h, r_mul_l;

  logic             w_accept, w_is_div, w_signed, w_sign_a, w_sign_b, w_dbz, w_req;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_dp_hi, w_dp_lo, w_fix_h, w_fix_l;
  logic [2*WIDTH-1:0] w_prod;

  assign w_accept = (r_state == StIdle) && bus.op_valid;
  assign w_is_div = (bus.op == OpDiv) || (bus.op == OpDivu);
  assign w_signed = (bus.op == OpMult) || (bus.op == OpDiv);
  assign w_sign_a = w_signed && bus.rs_val[WIDTH-1];
  assign w_sign_b = w_signed && bus.rt_val[WIDTH-1];
  assign w_a_mag  = w_sign_a ? -bus.rs_val : bus.rs_val;
  assign w_b_mag  = w_sign_b ? -bus.rt_val : bus.rt_val;
  assign w_dbz    = w_is_div && (bus.rt_val == '0);
  assign w_req    = bus.op_valid || (bus.cpu_choice != ChoiceNone);

  hilo_muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_step  (r_state == StRun),
    .i_is_div(r_is_div),
    .i_a     (w_a_mag),
    .i_b     (w_b_mag),
    .o_hi    (w_dp_hi),
    .o_lo    (w_dp_lo)
  );

  // Unsigned ops latch zero signs, so they pass through unchanged.
  assign w_prod = {w_dp_hi, w_dp_lo};
  always_comb begin
    {w_fix_h, w_fix_l} = w_prod;
    if (!r_is_div) begin
      if (r_sign_a ^ r_sign_b) {w_fix_h, w_fix_l} = -w_prod;
    end else begin
      if (r_sign_a ^ r_sign_b) w_fix_l = -w_dp_lo;
      if (r_sign_a) w_fix_h = -w_dp_hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_dbz    <= 1'b0;
      r_mul_h  <= '0;
      r_mul_l  <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_is_div <= w_is_div;
      r_sign_a <= w_sign_a;
      r_sign_b <= w_sign_b;
      r_dbz    <= w_dbz;
      if (w_dbz) begin
        r_mul_h <= bus.rs_val;
        r_mul_l <= '1;
      end
    end else if (r_state == StRun) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == StFix) begin
      r_mul_h <= w_fix_h;
      r_mul_l <= w_fix_l;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    bus.choice      = ChoiceNone;
    bus.busy        = 1'b1;
    bus.stall       = 1'b0;
    bus.done        = 1'b0;
    bus.div_by_zero = 1'b0;
    unique case (r_state)
      StIdle: begin
        bus.busy   = 1'b0;
        bus.choice = bus.cpu_choice;
        if (bus.op_valid) w_state_nxt = w_dbz ? StWb : StRun;
      end
      StRun: begin
        bus.stall = w_req;
        if (r_cnt == CntW'(WIDTH - 1)) w_state_nxt = StFix;
      end
      StFix: begin
        bus.stall   = w_req;
        w_state_nxt = StWb;
      end
      StWb: begin
        bus.stall       = w_req;
        bus.choice      = ChoiceDm;
        bus.done        = 1'b1;
        bus.div_by_zero = r_dbz;
        w_state_nxt     = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    // Reset also blanks the combinational passthrough.
    if (!rst_n) bus.choice = ChoiceNone;
  end

  assign bus.mul_h = r_mul_h;
  assign bus.mul_l = r_mul_l;
endmodule

// File: doc/hilo_muldiv_ctrl.md
HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 op_valid  in  1  mul/div instruction present this cycle.
REQ-005 op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 rs_val  in  WIDTH  multiplicand / dividend.
REQ-007 rt_val  in  WIDTH  multiplier / divisor.
REQ-008 cpu_choice  in  5  decoder Hi/Lo request, one-hot: MFHI 10000, MFLO 01000, MTHI 00100, MTLO 00010, else 00000.
REQ-009 choice  out  5  one-hot command to the Hi/Lo register file (adds D_M 00001).
REQ-010 mul_h  out  WIDTH  result for Hi (product high / remainder).
REQ-011 mul_l  out  WIDTH  result for Lo (product low / quotient).
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 stall  out  1  freeze PC and decode stage this cycle.
REQ-014 done  out  1  one-cycle pulse coincident with D_M write.
REQ-015 div_by_zero  out  1  one-cycle pulse with done when DIV/DIVU divisor is 0.

Function
REQ-016 States SHALL be IDLE, RUN, FIX, WB.
REQ-017 IDLE with op_valid high SHALL latch op, magnitudes of operands (signed ops) or raw operands (unsigned ops), operand signs, clear iteration counter, and go to RUN; stall low that cycle.
REQ-018 RUN SHALL perform exactly one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for WIDTH cycles, then go to FIX.
REQ-019 FIX SHALL negate the product when operand signs differ (MULT), negate the quotient when signs differ and give the remainder the dividend's sign (DIV); unsigned ops pass unchanged; then go to WB.
REQ-020 WB SHALL drive choice=00001 with final mul_h/mul_l, pulse done, return to IDLE.
REQ-021 Latency: accept at cycle 0, D_M write at cycle WIDTH+2 (34), IDLE again at cycle WIDTH+3.
REQ-022 DIV/DIVU with rt_val=0 SHALL skip RUN and FIX: WB at cycle 1, mul_h=rs_val, mul_l=all ones, div_by_zero pulsed.
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF SHALL give Lo 0x80000000, Hi 0.
REQ-024 op_valid while busy SHALL assert stall and not be accepted; it is accepted in the first IDLE cycle.
REQ-025 Non-zero cpu_choice while busy SHALL assert stall and choice SHALL not forward it.
REQ-026 In WB, D_M SHALL take priority; any simultaneous cpu_choice or op_valid is stalled that cycle.
REQ-027 In IDLE with no op_valid, choice SHALL equal cpu_choice combinationally, stall low.
REQ-028 mul_h/mul_l SHALL hold their last WB value between operations.

Reset
REQ-029 rst low SHALL immediately force IDLE, counter 0, choice 00000, mul_h/mul_l 0, busy/stall/done/div_by_zero 0.
REQ-030 Reset mid-operation SHALL abort without any D_M write; first post-reset cycle is IDLE.

Structure
REQ-031 Shared package muldiv_pkg SHALL hold WIDTH default, op codes, choice one-hot constants, state encoding.
REQ-032 One sub-module hilo_muldiv_datapath SHALL hold the accumulator/remainder/shift registers and single-step logic; the FSM, stall and choice muxing stay in hilo_muldiv_ctrl.

Verification
REQ-033 MULTU 0xFFFFFFFF x 2 -> at cycle 34 choice=00001, mul_h=0x00000001, mul_l=0xFFFFFFFE, done=1.
REQ-034 MULT -3 x 5 -> mul_h=0xFFFFFFFF, mul_l=0xFFFFFFF1 at cycle 34.
REQ-035 DIV -7 / 2 -> mul_l=0xFFFFFFFD, mul_h=0xFFFFFFFF; DIVU 7 / 0 -> cycle 1 WB, mul_h=7, mul_l=0xFFFFFFFF, div_by_zero=1.
REQ-036 cpu_choice=10000 at cycle 5 of a MULTU -> stall high cycles 5..34, choice=10000 at cycle 35.
REQ-037 rst low at RUN cycle 10 -> all outputs 0 same cycle, no 00001 ever seen on choice for that op.
